// File: rtl/booth_mult_pipe.sv
// Radix-4 Booth multiplier, fixed 6-stage pipeline with a single global stall enable.
// Per-transaction signed/unsigned operands; a sideband tag rides along with each operation.
module booth_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [1:0]           sm,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic [TAG_W-1:0]     tag_out
);

  localparam int AW = WIDTH + 2;       // extended multiplicand width
  localparam int BW = WIDTH + 3;       // {ext2, b, 0}
  localparam int ND = WIDTH / 2 + 1;   // Booth digits
  localparam int PW = 2 * WIDTH + 4;   // partial-product sum width
  localparam int NT = ND / 2 + 1;      // terms after pairwise add (last one holds the correction)

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
    $error("booth_mult_pipe: WIDTH must be even and >= 4");
  end

  logic adv;
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  // S1 capture
  logic             s1_v;
  logic [AW-1:0]    s1_a;
  logic [BW-1:0]    s1_b;
  logic [TAG_W-1:0] s1_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
    end else if (adv) begin
      s1_v   <= in_valid;
      s1_a   <= {{2{sm[1] & a[WIDTH-1]}}, a};
      s1_b   <= {{2{sm[0] & b[WIDTH-1]}}, b, 1'b0};
      s1_tag <= tag_in;
    end
  end

  // S2 Booth decode
  logic [ND-1:0]    d_sel1, d_sel2, d_neg;
  logic             s2_v;
  logic [ND-1:0]    s2_sel1, s2_sel2, s2_neg;
  logic [AW-1:0]    s2_a1, s2_a2;
  logic [TAG_W-1:0] s2_tag;

  always_comb begin
    d_sel1 = '0;
    d_sel2 = '0;
    d_neg  = '0;
    for (int i = 0; i < ND; i++) begin
      d_sel1[i] = s1_b[2*i] ^ s1_b[2*i+1];
      d_sel2[i] = (s1_b[2*i+2] & ~s1_b[2*i+1] & ~s1_b[2*i]) |
                  (~s1_b[2*i+2] & s1_b[2*i+1] & s1_b[2*i]);
      d_neg[i]  = s1_b[2*i+2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
    end else if (adv) begin
      s2_v    <= s1_v;
      s2_sel1 <= d_sel1;
      s2_sel2 <= d_sel2;
      s2_neg  <= d_neg;
      s2_a1   <= s1_a;
      s2_a2   <= {s1_a[AW-2:0], 1'b0};
      s2_tag  <= s1_tag;
    end
  end

  // S3 partial-product select; negative digits are inverted here, +1 added in S4
  logic [ND-1:0][AW-1:0] pp;
  logic                  s3_v;
  logic [ND-1:0][AW-1:0] s3_pp;
  logic [ND-1:0]         s3_neg;
  logic [TAG_W-1:0]      s3_tag;

  always_comb begin
    pp = '0;
    for (int i = 0; i < ND; i++) begin
      pp[i] = (({AW{s2_sel1[i]}} & s2_a1) | ({AW{s2_sel2[i]}} & s2_a2)) ^ {AW{s2_neg[i]}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v <= 1'b0;
    end else if (adv) begin
      s3_v   <= s2_v;
      s3_pp  <= pp;
      s3_neg <= s2_neg;
      s3_tag <= s2_tag;
    end
  end

  // S4 align, pairwise add, fold in negation correction
  logic [ND-1:0][PW-1:0] ext;
  logic [PW-1:0]         corr;
  logic [NT-1:0][PW-1:0] t4;
  logic                  s4_v;
  logic [NT-1:0][PW-1:0] s4_t;
  logic [TAG_W-1:0]      s4_tag;

  always_comb begin
    ext  = '0;
    corr = '0;
    t4   = '0;
    for (int i = 0; i < ND; i++) begin
      ext[i]      = {{(PW-AW){s3_pp[i][AW-1]}}, s3_pp[i]} << (2*i);
      corr[2*i]   = s3_neg[i];
    end
    for (int j = 0; j < ND / 2; j++) begin
      t4[j] = ext[2*j] + ext[2*j+1];
    end
    t4[NT-1] = corr;
    if ((ND % 2) == 1) t4[NT-1] = corr + ext[ND-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s4_v <= 1'b0;
    end else if (adv) begin
      s4_v   <= s3_v;
      s4_t   <= t4;
      s4_tag <= s3_tag;
    end
  end

  // S5 carry-save reduction to sum/carry pair
  logic [PW-1:0]    cs_s, cs_c, cs_m;
  logic             s5_v;
  logic [PW-1:0]    s5_s, s5_c;
  logic [TAG_W-1:0] s5_tag;

  always_comb begin
    cs_s = s4_t[0];
    cs_c = '0;
    cs_m = '0;
    for (int j = 1; j < NT; j++) begin
      cs_m = (cs_s & cs_c) | (cs_s & s4_t[j]) | (cs_c & s4_t[j]);
      cs_s = cs_s ^ cs_c ^ s4_t[j];
      cs_c = cs_m << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s5_v <= 1'b0;
    end else if (adv) begin
      s5_v   <= s4_v;
      s5_s   <= cs_s;
      s5_c   <= cs_c;
      s5_tag <= s4_tag;
    end
  end

  // S6 final add; output registers only update on a valid entry
  logic [PW-1:0] sum_w;
  logic          unused_sum_hi;
  assign sum_w         = s5_s + s5_c;
  assign unused_sum_hi = ^sum_w[PW-1:2*WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      p         <= '0;
      tag_out   <= '0;
    end else if (adv) begin
      out_valid <= s5_v;
      if (s5_v) begin
        p       <= sum_w[2*WIDTH-1:0];
        tag_out <= s5_tag;
      end
    end
  end

endmodule

// File: doc/booth_mult_pipe.md
Name: booth_mult_pipe

Overview:
Parametrised radix-4 Booth multiplier with a fixed 6-stage pipeline and full valid/ready flow control. Each operand is independently signed or unsigned per transaction. A sideband tag travels with each operand pair so that downstream logic can match results to requests. It is the general-width successor of the 8-bit fixed core and serves as the shared multiplier for DSP datapaths where the consumer may stall.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4; product width is 2*WIDTH.
TAG_W, 4, width of the sideband tag carried alongside each operation; must be >= 1.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
in_valid  input  1  operand pair on a/b/sm/tag_in is valid.
in_ready  output  1  block accepts the input this cycle.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
sm  input  2  sm[1]=1 treats a as signed; sm[0]=1 treats b as signed.
tag_in  input  TAG_W  sideband tag, returned unchanged with the result.
out_valid  output  1  p/tag_out hold a valid result.
out_ready  input  1  consumer accepts the result this cycle.
p  output  2*WIDTH  product, two's complement when either operand is signed, otherwise unsigned.
tag_out  output  TAG_W  tag of the result on p.

Behaviour:
- Clock and reset: one clock domain, clk. Reset rst is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values: out_valid=0, p=0, tag_out=0, and every internal stage valid bit=0. in_ready=1 in the cycle after reset is released. Reset asserted mid-operation discards every in-flight operation; no partial result may appear after reset.
- Accept: a transfer occurs on an edge where in_valid & in_ready.
- Release: a result is consumed on an edge where out_valid & out_ready.
- Stall model: one global enable, adv = ~out_valid | out_ready.
  - in_ready = adv, purely combinational from out_valid and out_ready.
  - When adv=0, every stage register, valid bit, p and tag_out hold their values.
  - When adv=1, all stages shift one position. Bubbles (valid=0) propagate and may be overwritten. p and tag_out update only when the last stage holds a valid entry; otherwise they keep their old value and out_valid=0.
- Latency: exactly 6 advancing edges from accept to out_valid=1. Stall cycles add to this one-for-one.
- Throughput: one operation per cycle when out_ready is held at 1.
- Ordering: strictly in order; tag_out always equals the tag_in of the operation shown on p.
- Pipeline stages:
  - S1 capture: extend a to WIDTH+2 bits, sign-extending if sm[1] and zero-extending otherwise. Form b as {ext2, b, 1'b0}, where ext2 is the sign bits of b if sm[0] and zeros otherwise.
  - S2 Booth decode: N = WIDTH/2+1 digits. Digit i uses b bits [2i+2:2i] and produces sel1x, sel2x and neg. Also register 1*a and 2*a.
  - S3 partial-product select: (sel1x&a | sel2x&2a) XOR {neg}, giving WIDTH+2 bits per digit.
  - S4: sign-extend each partial product i and shift it left by 2i to 2*WIDTH+4 bits. Sum the partial products pairwise. Add the neg correction word, with bit 2i = neg[i], into the unpaired term.
  - S5: reduce all remaining terms to two.
  - S6: final add; p is the low 2*WIDTH bits of the sum.
- Arithmetic: p must equal the exact product of the interpreted operands, modulo 2^(2*WIDTH), for all four sm modes. Because no product overflows, this is exact.
- Simultaneous events:
  - in_valid and out_ready can both be active while the pipe is full; both transfers complete on the same edge.
  - out_ready=1 while out_valid=0 has no effect.
  - While in_ready=0, in_valid and the input data may change freely; nothing is captured.
- Widths: operands that are not multiples of 2 are not supported. A generate-time check must fail elaboration if WIDTH is odd or less than 4.

Test Plan:
- WIDTH=8, sm=00, a=0xFF, b=0xFF, tag=3, out_ready=1 -> out_valid=1 exactly 6 edges after accept, p=0xFE01, tag_out=3.
- WIDTH=8, sm=11, a=0x80, b=0x80 -> p=0x4000. Then sm=11, a=0x7F, b=0x80 -> p=0xC080. Then sm=10, a=0xFF, b=0xFF -> p=0xFF01.
- WIDTH=8, 256 back-to-back random operations with tags 0..15 cycling, out_ready=1 -> one result per cycle, in order, all matching the reference model, with in_ready constantly 1.
- Stall: fill the pipe, then hold out_ready=0 for 10 cycles -> in_ready=0, p and tag_out stable, no result lost or duplicated. After out_ready returns to 1, the 6 queued results drain in order.
- Reset mid-stream: assert rst for 1 cycle with 4 operations in flight -> out_valid=0 and p=0 on the next edge, no stale result afterwards, and a new operation accepted right after reset is released returns in 6 cycles.
- WIDTH=16:
  - sm=00, a=b=0xFFFF -> p=0xFFFE0001.
  - sm=11, a=0x8000, b=0xFFFF -> p=0x00008000.
  - Randomised all-mode regression plus the corner operands 0, 1, max and min.
